// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX/MEM pipeline stage: access-size encodings,
// big-endian byte-enable constants and the registered stage payload.
package ex_mem_stage_pkg;

  // Access size as seen by the data-memory port.
  typedef enum logic [1:0] {
    SIZE_WORD = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_BYTE = 2'b10
  } mem_size_e;

  // Byte enables, bit 3 is the byte at address offset 0 (big-endian).
  localparam logic [3:0] BE_NONE  = 4'b0000;
  localparam logic [3:0] BE_WORD  = 4'b1111;
  localparam logic [3:0] BE_HALF0 = 4'b1100;
  localparam logic [3:0] BE_HALF2 = 4'b0011;
  localparam logic [3:0] BE_BYTE0 = 4'b1000;
  localparam logic [3:0] BE_BYTE1 = 4'b0100;
  localparam logic [3:0] BE_BYTE2 = 4'b0010;
  localparam logic [3:0] BE_BYTE3 = 4'b0001;

  // Everything the stage carries from EX into MEM.
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [3:0]  byte_en;
    logic [4:0]  rt_rd;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic        mem_byte;
    logic        mem_half;
    logic        mem_sign_ext;
    logic        addr_err_load;
    logic        addr_err_store;
  } ex_mem_t;

  // Byte wins when both size bits are set; neither means word.
  function automatic mem_size_e decode_size(input logic mem_byte, input logic mem_half);
    mem_size_e size;
    if (mem_byte) begin
      size = SIZE_BYTE;
    end else if (mem_half) begin
      size = SIZE_HALF;
    end else begin
      size = SIZE_WORD;
    end
    return size;
  endfunction

endpackage

// File: rtl/ex_mem_stage_mem_align.sv
// Combinational memory-access alignment: byte enables, lane-replicated store
// data and address-error detection from the low address bits and access size.
module mem_align
  import ex_mem_stage_pkg::*;
(
  input  logic [1:0]  addr_off_i,
  input  logic        mem_byte_i,
  input  logic        mem_half_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] rt_data_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] store_data_o,
  output logic        addr_err_load_o,
  output logic        addr_err_store_o
);

  mem_size_e   size_s;
  logic        aligned_s;
  logic        access_s;
  logic [3:0]  lane_be_s;

  assign size_s   = decode_size(mem_byte_i, mem_half_i);
  assign access_s = mem_read_i | mem_write_i;

  // Per-size alignment check, lane selection and store-data replication.
  always_comb begin
    aligned_s    = 1'b1;
    lane_be_s    = BE_NONE;
    store_data_o = rt_data_i;
    case (size_s)
      SIZE_BYTE: begin
        store_data_o = {4{rt_data_i[7:0]}};
        case (addr_off_i)
          2'b00:   lane_be_s = BE_BYTE0;
          2'b01:   lane_be_s = BE_BYTE1;
          2'b10:   lane_be_s = BE_BYTE2;
          2'b11:   lane_be_s = BE_BYTE3;
          default: lane_be_s = BE_NONE;
        endcase
      end
      SIZE_HALF: begin
        store_data_o = {2{rt_data_i[15:0]}};
        aligned_s    = (addr_off_i[0] == 1'b0);
        if (addr_off_i[1]) begin
          lane_be_s = BE_HALF2;
        end else begin
          lane_be_s = BE_HALF0;
        end
      end
      SIZE_WORD: begin
        aligned_s = (addr_off_i == 2'b00);
        lane_be_s = BE_WORD;
      end
      default: begin
        aligned_s = 1'b1;
        lane_be_s = BE_NONE;
      end
    endcase
  end

  // Enables only reach the memory for an aligned load or store.
  always_comb begin
    if (access_s && aligned_s) begin
      byte_en_o = lane_be_s;
    end else begin
      byte_en_o = BE_NONE;
    end
  end

  assign addr_err_load_o  = mem_read_i  & ~aligned_s;
  assign addr_err_store_o = mem_write_i & ~aligned_s;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register. Captures the execute result plus memory and
// writeback controls, with hold (M_Stall), bubble (EX_Stall/EX_Flush) and
// misaligned-access suppression. All outputs come straight from flops.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        EX_Stall,
  input  logic        EX_Flush,
  input  logic        M_Stall,
  input  logic [31:0] EX_ALUResult,
  input  logic [31:0] EX_RtData,
  input  logic [4:0]  EX_RtRd,
  input  logic        EX_RegWrite,
  input  logic        EX_MemtoReg,
  input  logic        EX_MemRead,
  input  logic        EX_MemWrite,
  input  logic        EX_MemByte,
  input  logic        EX_MemHalf,
  input  logic        EX_MemSignExtend,
  output logic [31:0] M_ALUResult,
  output logic [31:0] M_StoreData,
  output logic [3:0]  M_ByteEn,
  output logic [4:0]  M_RtRd,
  output logic        M_RegWrite,
  output logic        M_MemtoReg,
  output logic        M_MemRead,
  output logic        M_MemWrite,
  output logic        M_MemByte,
  output logic        M_MemHalf,
  output logic        M_MemSignExtend,
  output logic        M_AddrErrLoad,
  output logic        M_AddrErrStore
);

  ex_mem_t     stage_d;
  ex_mem_t     stage_q;
  logic [3:0]  byte_en_s;
  logic [31:0] store_data_s;
  logic        err_load_s;
  logic        err_store_s;
  logic        access_err_s;

  mem_align u_mem_align (
    .addr_off_i      (EX_ALUResult[1:0]),
    .mem_byte_i      (EX_MemByte),
    .mem_half_i      (EX_MemHalf),
    .mem_read_i      (EX_MemRead),
    .mem_write_i     (EX_MemWrite),
    .rt_data_i       (EX_RtData),
    .byte_en_o       (byte_en_s),
    .store_data_o    (store_data_s),
    .addr_err_load_o (err_load_s),
    .addr_err_store_o(err_store_s)
  );

  assign access_err_s = err_load_s | err_store_s;

  // Next-state selection: hold under M_Stall, bubble on EX stall/flush, else capture.
  always_comb begin
    stage_d = stage_q;
    if (M_Stall) begin
      stage_d = stage_q;
    end else if (EX_Stall || EX_Flush) begin
      // Bubble kills side effects but keeps data, index and size fields.
      stage_d.reg_write      = 1'b0;
      stage_d.mem_to_reg     = 1'b0;
      stage_d.mem_read       = 1'b0;
      stage_d.mem_write      = 1'b0;
      stage_d.byte_en        = BE_NONE;
      stage_d.addr_err_load  = 1'b0;
      stage_d.addr_err_store = 1'b0;
    end else begin
      // A faulting access keeps its address for BadVAddr but has no side effects.
      stage_d.alu_result     = EX_ALUResult;
      stage_d.store_data     = store_data_s;
      stage_d.byte_en        = byte_en_s;
      stage_d.rt_rd          = EX_RtRd;
      stage_d.reg_write      = EX_RegWrite & ~access_err_s;
      stage_d.mem_to_reg     = EX_MemtoReg;
      stage_d.mem_read       = EX_MemRead & ~access_err_s;
      stage_d.mem_write      = EX_MemWrite & ~access_err_s;
      stage_d.mem_byte       = EX_MemByte;
      stage_d.mem_half       = EX_MemHalf;
      stage_d.mem_sign_ext   = EX_MemSignExtend;
      stage_d.addr_err_load  = err_load_s;
      stage_d.addr_err_store = err_store_s;
    end
  end

  // Stage register with synchronous reset taking priority over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign M_ALUResult     = stage_q.alu_result;
  assign M_StoreData     = stage_q.store_data;
  assign M_ByteEn        = stage_q.byte_en;
  assign M_RtRd          = stage_q.rt_rd;
  assign M_RegWrite      = stage_q.reg_write;
  assign M_MemtoReg      = stage_q.mem_to_reg;
  assign M_MemRead       = stage_q.mem_read;
  assign M_MemWrite      = stage_q.mem_write;
  assign M_MemByte       = stage_q.mem_byte;
  assign M_MemHalf       = stage_q.mem_half;
  assign M_MemSignExtend = stage_q.mem_sign_ext;
  assign M_AddrErrLoad   = stage_q.addr_err_load;
  assign M_AddrErrStore  = stage_q.addr_err_store;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed scoreboard bench for ex_mem_stage: the driver pushes hand-computed
// expectations tagged with the edge they belong to; a monitor compares them.
module tb_ex_mem_stage;

  logic        clock = 1'b0;
  logic        reset, EX_Stall, EX_Flush, M_Stall;
  logic [31:0] EX_ALUResult, EX_RtData;
  logic [4:0]  EX_RtRd;
  logic        EX_RegWrite, EX_MemtoReg, EX_MemRead, EX_MemWrite;
  logic        EX_MemByte, EX_MemHalf, EX_MemSignExtend;
  logic [31:0] M_ALUResult, M_StoreData;
  logic [3:0]  M_ByteEn;
  logic [4:0]  M_RtRd;
  logic        M_RegWrite, M_MemtoReg, M_MemRead, M_MemWrite;
  logic        M_MemByte, M_MemHalf, M_MemSignExtend, M_AddrErrLoad, M_AddrErrStore;

  // alu, sd, be, rd, rw, m2r, mr, mw, mb, mh, mse, ael, aes
  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [3:0]  be;
    logic [4:0]  rd;
    logic rw, m2r, mr, mw, mb, mh, mse, ael, aes;
  } exp_t;

  typedef struct {
    int   due;
    exp_t e;
  } sb_t;

  sb_t  sb_q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t last;

  ex_mem_stage dut (
    .clock(clock), .reset(reset), .EX_Stall(EX_Stall), .EX_Flush(EX_Flush), .M_Stall(M_Stall),
    .EX_ALUResult(EX_ALUResult), .EX_RtData(EX_RtData), .EX_RtRd(EX_RtRd),
    .EX_RegWrite(EX_RegWrite), .EX_MemtoReg(EX_MemtoReg), .EX_MemRead(EX_MemRead),
    .EX_MemWrite(EX_MemWrite), .EX_MemByte(EX_MemByte), .EX_MemHalf(EX_MemHalf),
    .EX_MemSignExtend(EX_MemSignExtend),
    .M_ALUResult(M_ALUResult), .M_StoreData(M_StoreData), .M_ByteEn(M_ByteEn), .M_RtRd(M_RtRd),
    .M_RegWrite(M_RegWrite), .M_MemtoReg(M_MemtoReg), .M_MemRead(M_MemRead),
    .M_MemWrite(M_MemWrite), .M_MemByte(M_MemByte), .M_MemHalf(M_MemHalf),
    .M_MemSignExtend(M_MemSignExtend), .M_AddrErrLoad(M_AddrErrLoad), .M_AddrErrStore(M_AddrErrStore)
  );

  always #5 clock = ~clock;

  // Edge counter used to tag when each expectation becomes visible.
  always @(posedge clock) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [31:0] alu, input logic [31:0] sd, input logic [3:0] be,
                              input logic [4:0] rd, input logic rw, input logic m2r, input logic mr,
                              input logic mw, input logic mb, input logic mh, input logic mse,
                              input logic ael, input logic aes);
    exp_t e;
    e = '{alu, sd, be, rd, rw, m2r, mr, mw, mb, mh, mse, ael, aes};
    return e;
  endfunction

  // Drive one cycle of EX inputs and queue what the next edge must produce.
  task automatic apply(input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] rd,
                       input logic rw, input logic m2r, input logic mr, input logic mw,
                       input logic mb, input logic mh, input logic mse,
                       input logic st, input logic fl, input logic ms, input logic rst,
                       input exp_t e);
    sb_t s;
    EX_ALUResult = alu; EX_RtData = rt; EX_RtRd = rd;
    EX_RegWrite = rw; EX_MemtoReg = m2r; EX_MemRead = mr; EX_MemWrite = mw;
    EX_MemByte = mb; EX_MemHalf = mh; EX_MemSignExtend = mse;
    EX_Stall = st; EX_Flush = fl; M_Stall = ms; reset = rst;
    s.due = cyc + 1;
    s.e   = e;
    sb_q.push_back(s);
    last = e;
    @(posedge clock);
    #1;
  endtask

  // Monitor: on the falling edge, compare outputs against the entry due now.
  always @(negedge clock) begin
    exp_t act;
    sb_t  s;
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      s = sb_q.pop_front();
      act = '{M_ALUResult, M_StoreData, M_ByteEn, M_RtRd, M_RegWrite, M_MemtoReg, M_MemRead,
              M_MemWrite, M_MemByte, M_MemHalf, M_MemSignExtend, M_AddrErrLoad, M_AddrErrStore};
      total = total + 1;
      if (act !== s.e) begin
        bad = bad + 1;
        $display("FAIL stage@cyc%0d: got alu=%h sd=%h be=%b rd=%0d ctl(rw,m2r,mr,mw,mb,mh,mse,ael,aes)=%b need alu=%h sd=%h be=%b rd=%0d ctl=%b",
                 cyc, act.alu, act.sd, act.be, act.rd, act[8:0],
                 s.e.alu, s.e.sd, s.e.be, s.e.rd, s.e[8:0]);
      end
    end
  end

  initial begin
    exp_t hold_e;
    //          alu            rt            rd    rw m2r mr mw mb mh mse st fl ms rst
    // Reset: everything zero.
    apply(32'h0000_0000, 32'h0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
          mk(32'h0, 32'h0, 4'b0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    // Aligned store word.
    apply(32'h1000_0004, 32'hDEAD_BEEF, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
          mk(32'h1000_0004, 32'hDEAD_BEEF, 4'b1111, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    // Store byte sweep over offsets 0..3.
    apply(32'h0000_3000, 32'h0000_00A5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
          mk(32'h0000_3000, 32'hA5A5_A5A5, 4'b1000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    apply(32'h0000_3001, 32'h0000_00A5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
          mk(32'h0000_3001, 32'hA5A5_A5A5, 4'b0100, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    apply(32'h0000_3002, 32'h0000_00A5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
          mk(32'h0000_3002, 32'hA5A5_A5A5, 4'b0010, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    apply(32'h0000_3003, 32'h0000_00A5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
          mk(32'h0000_3003, 32'hA5A5_A5A5, 4'b0001, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    // Misaligned load half at 0x2003: error flagged, side effects suppressed.
    apply(32'h0000_2003, 32'h1234_5678, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
          mk(32'h0000_2003, 32'h5678_5678, 4'b0000, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
    // Aligned load half at offset 2.
    apply(32'h0000_2002, 32'h0000_BEEF, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
          mk(32'h0000_2002, 32'hBEEF_BEEF, 4'b0011, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    // M_Stall for 3 cycles with changing EX inputs and a flush pulse: hold.
    hold_e = last;
    apply(32'h0000_4444, 32'h1111_1111, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, hold_e);
    apply(32'h0000_4448, 32'h2222_2222, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, hold_e);
    apply(32'h0000_444C, 32'h3333_3333, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, hold_e);
    // Release: capture current EX inputs (word load).
    apply(32'h0000_5000, 32'hCAFE_F00D, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
          mk(32'h0000_5000, 32'hCAFE_F00D, 4'b1111, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    // Flush with a valid store: bubble, data/index/size held.
    apply(32'h0000_6000, 32'h1122_3344, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
          mk(32'h0000_5000, 32'hCAFE_F00D, 4'b0000, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    // EX_Stall with a store half: still a bubble.
    apply(32'h0000_6002, 32'hAABB_CCDD, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
          mk(32'h0000_5000, 32'hCAFE_F00D, 4'b0000, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    // Same store half released.
    apply(32'h0000_6002, 32'hAABB_CCDD, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
          mk(32'h0000_6002, 32'hCCDD_CCDD, 4'b0011, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    // Byte and half both set: treated as byte at offset 1.
    apply(32'h0000_6101, 32'h0000_0077, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
          mk(32'h0000_6101, 32'h7777_7777, 4'b0100, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    // Misaligned store word.
    apply(32'h0000_7001, 32'h0102_0304, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
          mk(32'h0000_7001, 32'h0102_0304, 4'b0000, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    // Non-memory ALU op with odd result: no error, RegWrite kept.
    apply(32'h0000_8003, 32'h0000_0000, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
          mk(32'h0000_8003, 32'h0000_0000, 4'b0000, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    // One stall cycle, then reset during the stall clears everything.
    hold_e = last;
    apply(32'h0000_9999, 32'hFFFF_FFFF, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, hold_e);
    apply(32'h0000_9999, 32'hFFFF_FFFF, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
          mk(32'h0, 32'h0, 4'b0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    // First capture after reset: signed byte load at offset 3.
    apply(32'h0000_9003, 32'h0000_0000, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
          mk(32'h0000_9003, 32'h0000_0000, 4'b0001, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    // Idle and drain the scoreboard within a bounded number of cycles.
    EX_RegWrite = 1'b0; EX_MemRead = 1'b0; EX_MemWrite = 1'b0; EX_Flush = 1'b1;
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clock);
    @(negedge clock);
    #1;
    if (sb_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: %0d expectations left, need 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
